// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and the data RAM: a FIFO of full-word stores drained one per cycle.
// Loads wait for older stores to drain; define STORE_FWD_EN to forward exact-address matches instead.
module mem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [31:0]      req_address,
   input  logic [31:0]      req_data,
   input  logic             req_word,
   input  logic             req_sign,
   input  logic             drain_en,
   output logic             resp_valid,
   output logic [31:0]      resp_data,
   output logic [31:0]      ram_address,
   output logic [31:0]      ram_dataIn,
   output logic             ram_write,
   output logic             ram_read,
   output logic             ram_word,
   output logic             ram_sign,
   input  logic [31:0]      ram_dataOut,
   output logic [PTR_W:0]   buf_count,
   output logic             buf_empty
);

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ZERO_COUNT = {(PTR_W+1){1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [31:0]      addr_mem_r [DEPTH];
   logic [31:0]      data_mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             resp_valid_r;
   logic [31:0]      resp_data_r;

   logic             not_empty_s;
   logic             push_s;
   logic             pop_s;
   logic             load_acc_s;
   logic             fwd_hit_s;
   logic [31:0]      fwd_data_s;

   assign not_empty_s = (count_r != ZERO_COUNT);

`ifdef STORE_FWD_EN
   function automatic logic [31:0] extend_half(input logic [15:0] half, input logic sign);
      return {{16{sign & half[15]}}, half};
   endfunction

   // Walk oldest to youngest so the youngest exact-address match wins.
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      logic [31:0]      word_v;
      idx_v     = rd_ptr_r;
      word_v    = 32'd0;
      fwd_hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idx_v = rd_ptr_r + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_r) && (addr_mem_r[idx_v] == req_address)) begin
            fwd_hit_s = 1'b1;
            word_v    = data_mem_r[idx_v];
         end else begin
            fwd_hit_s = fwd_hit_s;
         end
      end
      if (req_word) begin
         fwd_data_s = word_v;
      end else begin
         fwd_data_s = extend_half(word_v[15:0], req_sign);
      end
   end
`else
   assign fwd_hit_s  = 1'b0;
   assign fwd_data_s = 32'd0;
`endif

   // Stores need a free slot regardless of drain; loads need an empty buffer (or a forward hit).
   always_comb begin
      if (!rst_n) begin
         req_ready = 1'b0;
      end else if (req_write) begin
         req_ready = (count_r != FULL_COUNT);
      end else begin
         req_ready = !not_empty_s || fwd_hit_s;
      end
   end

   assign push_s     = req_valid && req_ready && req_write;
   assign load_acc_s = req_valid && req_ready && !req_write;
   assign pop_s      = not_empty_s && drain_en;

   // RAM port mux: the drain owns the port whenever the buffer holds anything.
   always_comb begin
      ram_address = 32'd0;
      ram_dataIn  = 32'd0;
      ram_write   = 1'b0;
      ram_read    = 1'b0;
      ram_word    = 1'b1;
      ram_sign    = 1'b0;
      if (not_empty_s) begin
         ram_address = addr_mem_r[rd_ptr_r];
         ram_dataIn  = data_mem_r[rd_ptr_r];
         ram_write   = drain_en;
      end else if (load_acc_s) begin
         ram_address = req_address;
         ram_read    = 1'b1;
         ram_word    = req_word;
         ram_sign    = req_sign;
      end else begin
         ram_write   = 1'b0;
      end
   end

   // Entry storage; stale contents are harmless because occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= req_address;
         data_mem_r[wr_ptr_r] <= req_data;
      end
   end

   // Pointers and occupancy; a reset discards buffered stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= ZERO_COUNT;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered load response: one-cycle valid pulse, data held between loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_r <= 1'b0;
         resp_data_r  <= 32'd0;
      end else begin
         resp_valid_r <= load_acc_s;
         if (load_acc_s) begin
            resp_data_r <= fwd_hit_s ? fwd_data_s : ram_dataOut;
         end
      end
   end

   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign buf_count  = count_r;
   assign buf_empty  = !not_empty_s;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: a queue-based reference model predicts handshakes,
// RAM port activity and load responses; a separate monitor checks responses as they appear.
module tb_mem_store_buffer;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic req_valid, req_ready, req_write, req_word, req_sign, drain_en;
   logic [31:0] req_address, req_data, resp_data;
   logic resp_valid;
   logic [31:0] ram_address, ram_dataIn, ram_dataOut;
   logic ram_write, ram_read, ram_word, ram_sign;
   logic [PTR_W:0] buf_count;
   logic buf_empty;
   logic ram_clear;

   always #5 clk = ~clk;

   mem_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_address(req_address), .req_data(req_data), .req_word(req_word), .req_sign(req_sign),
      .drain_en(drain_en), .resp_valid(resp_valid), .resp_data(resp_data),
      .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_write(ram_write),
      .ram_read(ram_read), .ram_word(ram_word), .ram_sign(ram_sign),
      .ram_dataOut(ram_dataOut), .buf_count(buf_count), .buf_empty(buf_empty)
   );

   // Environment RAM: word array, little-endian halfword select, combinational read.
   logic [31:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= 32'd0;
      end else if (ram_write) begin
         ram_mem[ram_address[7:2]] <= ram_dataIn;
      end
   end
   always @* begin
      logic [31:0] w;
      logic [15:0] h;
      w = ram_mem[ram_address[7:2]];
      h = ram_address[1] ? w[31:16] : w[15:0];
      if (!ram_read) ram_dataOut = 32'hDEAD_BEEF;
      else if (ram_word) ram_dataOut = w;
      else ram_dataOut = {{16{ram_sign & h[15]}}, h};
   end

   typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
   typedef struct { logic [31:0] d; int c; } exp_t;
   ent_t mq[$];
   exp_t sb[$];
   logic [31:0] ref_mem [64];
   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic s);
      return {{16{s & h[15]}}, h};
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic wd, input logic sg);
      logic [31:0] w;
      w = ref_mem[a[7:2]];
      if (wd) return w;
      return ext_half(a[1] ? w[31:16] : w[15:0], sg);
   endfunction

   // One clock of stimulus: drive after the edge, check at the falling edge, then advance the model.
   task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic wd, input logic sg, input logic dr, output logic acc);
      logic exp_ready, hit, exp_read, draining;
      logic [31:0] fw, rd;
      @(posedge clk); #1;
      req_valid = v; req_write = w; req_address = a; req_data = d;
      req_word = wd; req_sign = sg; drain_en = dr;
      @(negedge clk);
      hit = 1'b0; fw = 32'd0;
      foreach (mq[i]) if (mq[i].a == a) begin hit = 1'b1; fw = mq[i].d; end
`ifdef STORE_FWD_EN
      exp_ready = w ? (mq.size() < DEPTH) : (mq.size() == 0 || hit);
`else
      exp_ready = w ? (mq.size() < DEPTH) : (mq.size() == 0);
`endif
      draining = (mq.size() > 0) && dr;
      exp_read = v && !w && exp_ready && (mq.size() == 0);
      check("buf_count", 32'(buf_count), 32'(mq.size()));
      check("buf_empty", 32'(buf_empty), 32'(mq.size() == 0));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("ram_write", 32'(ram_write), 32'(draining));
      check("ram_read", 32'(ram_read), 32'(exp_read));
      if (draining) begin
         check("drain_address", ram_address, mq[0].a);
         check("drain_data", ram_dataIn, mq[0].d);
      end
      if (exp_read) begin
         check("load_address", ram_address, a);
         check("load_word", 32'(ram_word), 32'(wd));
      end
      if (!exp_read && mq.size() == 0) begin
         check("idle_address", ram_address, 32'd0);
         check("idle_word", 32'(ram_word), 32'd1);
      end
      acc = v && exp_ready;
      if (acc && !w) begin
         rd = (mq.size() == 0) ? model_read(a, wd, sg) : (wd ? fw : ext_half(fw[15:0], sg));
         sb.push_back('{rd, cyc});
      end
      if (draining) begin
         ref_mem[mq[0].a[7:2]] = mq[0].d;
         void'(mq.pop_front());
      end
      if (acc && w) mq.push_back('{a, d});
   endtask

   task automatic idle(input logic dr, input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, dr, acc);
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic wd, input logic sg, input logic dr);
      logic acc;
      int n;
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
         step(1'b1, w, a, d, wd, sg, dr, acc);
         n++;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      req_valid = 1'b0; drain_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_buf_count", 32'(buf_count), 32'd0);
      check("rst_buf_empty", 32'(buf_empty), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      mq.delete();
      sb.delete();
      @(negedge clk); @(negedge clk); #2;
      rst_n = 1'b1;
   endtask

   // Response monitor: pops the scoreboard whenever the DUT presents a load result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) continue;
         if (resp_valid) begin
            if (sb.size() == 0) begin
               check("resp_spurious", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("resp_data", resp_data, e.d);
               check("resp_latency", 32'(cyc), 32'(e.c + 1));
            end
         end else if (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            check("resp_missing", 32'd0, 32'd1);
         end
      end
   end

   initial begin
      logic acc;
      logic [31:0] a;
      logic w, wd;
      rst_n = 1'b0; ram_clear = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_address = 32'd0; req_data = 32'd0;
      req_word = 1'b1; req_sign = 1'b0; drain_en = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_buf_count", 32'(buf_count), 32'd0);
      check("reset_buf_empty", 32'(buf_empty), 32'd1);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_data", resp_data, 32'd0);
      check("reset_ram_write", 32'(ram_write), 32'd0);
      ram_clear = 1'b0;
      #2 rst_n = 1'b1;

      // Basic store then word load
      send(1'b1, 32'd24, 32'hF00F_F176, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 2);
      send(1'b0, 32'd24, 32'd0, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 2);

      // Halfword loads, signed and unsigned
      send(1'b1, 32'd24, 32'h0000_F176, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 1);
      send(1'b0, 32'd24, 32'd0, 1'b0, 1'b1, 1'b1);
      send(1'b0, 32'd24, 32'd0, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 2);

      // Full buffer: five stores with drain held off, then release
      for (int i = 0; i < 4; i++) send(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'd16, 32'hCAFE_0016, 1'b1, 1'b0, 1'b0, acc);
      send(1'b1, 32'd16, 32'hCAFE_0016, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 6);

      // Load stalled behind an older store
      send(1'b1, 32'd40, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
      send(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      send(1'b0, 32'd40, 32'd0, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 2);

      // Reset with stores still buffered: nothing may reach the RAM afterwards
      for (int i = 0; i < 3; i++) send(1'b1, 32'(8 + i * 4), 32'hEEEE_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      reset_pulse();
      idle(1'b1, 4);
      send(1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 2);

`ifdef STORE_FWD_EN
      // Forwarding from the youngest matching entry
      send(1'b1, 32'd8, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0);
      send(1'b1, 32'd8, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
      send(1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0);
      send(1'b0, 32'd8, 32'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 1'b0, acc);
      send(1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 1'b1);
      idle(1'b1, 3);
`endif

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         w  = 1'($urandom_range(0, 1));
         wd = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 7)) << 2;
         if (!w && !wd) a = a | (32'($urandom_range(0, 1)) << 1);
         step($urandom_range(0, 3) != 0, w, a, $urandom, wd, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0, acc);
      end
      idle(1'b1, 8);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
